// File: rtl/mux_pkg.sv
// Shared definitions for the mux scan sequencer and the mux it drives.
package mux_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_NCH   = 16;

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        SAMPLE,
        HOLD,
        DONE
    } state_e;

endpackage

// File: rtl/mux16.sv
// 16:1 combinational mux of WIDTH-bit inputs; the block the sequencer scans.
module mux16
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] in_data [16],
    input  logic [3:0]       sel,
    output logic [WIDTH-1:0] y
);

    // Pure select: the sequencer provides the settle cycle before sampling.
    assign y = in_data[sel];

endmodule

// File: rtl/mux_scan_seq.sv
// Sweeps the select of an external NCH:1 mux over the enabled channels,
// samples each one after a settle cycle and hands it out over valid/ready.
module mux_scan_seq
    import mux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NCH   = DEF_NCH,
    localparam int SEL_W = $clog2(NCH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NCH-1:0]   mask,
    output logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] mux_out,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(NCH - 1);

    state_e           state_q, state_d;
    logic [NCH-1:0]   mask_q, mask_d;
    logic [SEL_W-1:0] ch_q, ch_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SEL_W-1:0] out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic             last_ch;

    assign last_ch = (ch_q == LAST_CH);

    // Next-state and datapath updates; every register holds unless told otherwise.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        ch_d        = ch_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    mask_d  = mask;
                    ch_d    = '0;
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (mask_q[ch_q]) begin
                    state_d = SAMPLE;
                end else if (last_ch) begin
                    state_d = DONE;
                end else begin
                    ch_d = ch_q + SEL_W'(1);
                end
            end
            SAMPLE: begin
                out_data_d  = mux_out;
                out_ch_d    = ch_q;
                out_valid_d = 1'b1;
                state_d     = HOLD;
            end
            HOLD: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (last_ch) begin
                        state_d = DONE;
                    end else begin
                        ch_d    = ch_q + SEL_W'(1);
                        state_d = SCAN;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any sweep in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mask_q      <= '0;
            ch_q        <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mask_q      <= mask_d;
            ch_q        <= ch_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
        end
    end

    // ch only moves on the way into SCAN, so it doubles as the held select.
    assign sel       = ch_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_mux_scan_seq.sv
// Bench for mux_scan_seq driving a mux16: table-driven sweeps, random sweeps
// against a sample-order/timing model, and a mid-sweep asynchronous reset.
module tb_mux_scan_seq;
    import mux_pkg::*;

    localparam int WIDTH = DEF_WIDTH;
    localparam int NCH   = DEF_NCH;
    localparam int SEL_W = $clog2(NCH);

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [NCH-1:0]   mask;
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] out_data;
    logic [SEL_W-1:0] out_ch;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] in_data [16];

    always #5 clk = ~clk;

    mux16 #(.WIDTH(WIDTH)) u_mux (
        .in_data (in_data),
        .sel     (sel),
        .y       (mux_out)
    );

    mux_scan_seq #(.WIDTH(WIDTH), .NCH(NCH)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .mask      (mask),
        .sel       (sel),
        .mux_out   (mux_out),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int stall_tab [NCH];

    typedef struct {
        logic [15:0] mask;
        int          stall0;
        int          fill;
        bit          perturb;
        int          exp_busy;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic fill_data(input int kind);
        for (int i = 0; i < 16; i++) begin
            if (kind == 1) in_data[i] = WIDTH'(i);
            else           in_data[i] = WIDTH'($urandom);
        end
        if (kind == 2) in_data[0] = 4'hA;
    endtask

    // One full sweep. The model lists enabled channels in order and the
    // cycle each should appear: skipped channel = 1 cycle, enabled channel =
    // scan + settle + (stall+1) hold cycles, plus one done cycle at the end.
    task automatic do_sweep(input logic [NCH-1:0] m, input bit perturb,
                            input int exp_busy_in, input string tag);
        int exp_ch [$];
        int exp_t  [$];
        int acc, pop, exp_busy, busy_cnt, done_cnt, k, stall_left;
        logic [WIDTH-1:0] held_d;
        logic [SEL_W-1:0] held_c;
        acc = 0;
        pop = 0;
        for (int i = 0; i < NCH; i++) begin
            if (m[i]) begin
                exp_ch.push_back(i);
                exp_t.push_back(i + acc + 2);
                acc += stall_tab[pop] + 2;
                pop++;
            end
        end
        exp_busy = NCH + pop + 1;
        for (int j = 0; j < pop; j++) exp_busy += stall_tab[j] + 1;
        if (exp_busy_in >= 0) exp_busy = exp_busy_in;

        @(negedge clk);
        mask = m;
        start = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        if (perturb) mask = ~m;
        busy_cnt = 0;
        done_cnt = 0;
        k = 0;
        stall_left = -1;
        held_d = '0;
        held_c = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!busy) break;
            busy_cnt++;
            if (done) done_cnt++;
            if (out_valid) begin
                if (stall_left < 0) begin
                    if (k < pop) begin
                        check({tag, " out_ch"}, 32'(out_ch), 32'(exp_ch[k]));
                        check({tag, " out_data"}, 32'(out_data), 32'(in_data[exp_ch[k]]));
                        check({tag, " valid cycle"}, 32'(cyc), 32'(exp_t[k]));
                        stall_left = stall_tab[k];
                    end else begin
                        check({tag, " extra sample"}, 32'(out_ch), 32'hFFFF_FFFF);
                        stall_left = 0;
                    end
                    held_d = out_data;
                    held_c = out_ch;
                end else begin
                    check({tag, " hold data"}, 32'(out_data), 32'(held_d));
                    check({tag, " hold ch"}, 32'(out_ch), 32'(held_c));
                end
                out_ready = (stall_left == 0);
                if (stall_left == 0) begin
                    k++;
                    stall_left = -1;
                end else begin
                    stall_left--;
                end
            end else begin
                out_ready = 1'($urandom_range(0, 1));
            end
            start = perturb && (cyc == 3);
            if (perturb && cyc == 3) mask = NCH'($urandom);
            @(negedge clk);
        end
        out_ready = 1'b0;
        start = 1'b0;
        check({tag, " busy cycles"}, 32'(busy_cnt), 32'(exp_busy));
        check({tag, " done pulses"}, 32'(done_cnt), 32'd1);
        check({tag, " samples"}, 32'(k), 32'(pop));
        check({tag, " idle done"}, 32'(done), 32'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t vecs [6];
        bit hit;
        vecs[0] = '{16'h0001, 0, 2, 1'b0, 19};
        vecs[1] = '{16'hFFFF, 0, 1, 1'b0, 49};
        vecs[2] = '{16'h8001, 5, 1, 1'b0, 26};
        vecs[3] = '{16'h0000, 0, 0, 1'b0, 17};
        vecs[4] = '{16'h00F0, 0, 0, 1'b1, 25};
        vecs[5] = '{16'h8000, 2, 0, 1'b0, 21};

        rst = 1'b1;
        start = 1'b0;
        mask = '0;
        out_ready = 1'b0;
        fill_data(0);
        repeat (2) @(negedge clk);
        check("reset sel", 32'(sel), 32'd0);
        check("reset out", {out_valid, busy, done, 29'(out_data)}, 32'd0);
        check("reset out_ch", 32'(out_ch), 32'd0);
        rst = 1'b0;

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < NCH; i++) stall_tab[i] = 0;
            stall_tab[0] = vecs[v].stall0;
            fill_data(vecs[v].fill);
            do_sweep(vecs[v].mask, vecs[v].perturb, vecs[v].exp_busy, $sformatf("vec%0d", v));
        end

        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < NCH; i++) stall_tab[i] = $urandom_range(0, 3);
            fill_data(0);
            do_sweep(NCH'($urandom & $urandom), 1'($urandom_range(0, 1)), -1,
                     $sformatf("rnd%0d", r));
        end

        // Asynchronous reset while holding channel 5, then restart.
        for (int i = 0; i < NCH; i++) stall_tab[i] = 0;
        fill_data(0);
        in_data[5] = 4'hF;
        @(negedge clk);
        mask = 16'h0020;
        start = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (out_valid && out_ch == 4'd5) begin
                hit = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("rst reach hold ch5", 32'(hit), 32'd1);
        check("rst pre data", 32'(out_data), 32'hF);
        #2 rst = 1'b1;
        #1;
        check("rst async sel", 32'(sel), 32'd0);
        check("rst async flags", {29'd0, out_valid, busy, done}, 32'd0);
        check("rst async data", {24'd0, 4'(out_ch), 4'(out_data)}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst no done", 32'(done), 32'd0);
        end
        rst = 1'b0;
        @(negedge clk);
        check("rst idle busy", 32'(busy), 32'd0);
        in_data[0] = 4'h3;
        do_sweep(16'h0001, 1'b0, 19, "after rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
